apb_gpio_regs: RTL

- APB3 slave register block that sits directly downstream of the SPI-to-APB bridge and consumes the APB transfers the bridge issues.
- Provides the GPIO expander function:
  - output data and direction registers;
  - synchronised input sampling;
  - per-pin edge-detect interrupts with write-1-to-clear status and a single level interrupt output.

---
 rtl/gpio_regs_pkg.sv | 14 +
 rtl/gpio_sync_edge.sv | 38 +++
 rtl/apb_gpio_regs.sv | 122 ++++++++++++
 3 files changed

// File: rtl/gpio_regs_pkg.sv
// Shared constants for the APB GPIO expander register block.
// Register indices are the low ADDR_W bits of paddr; anything above REG_IS is unmapped.
package gpio_regs_pkg;

    localparam int unsigned DATA_W = 8;

    localparam int unsigned REG_DOUT = 0;
    localparam int unsigned REG_DIR  = 1;
    localparam int unsigned REG_DIN  = 2;
    localparam int unsigned REG_IE   = 3;
    localparam int unsigned REG_EDGE = 4;
    localparam int unsigned REG_IS   = 5;

endpackage

// File: rtl/gpio_sync_edge.sv
// Input conditioning for the GPIO pins: two-flop synchroniser, edge history and
// per-pin edge selection.
//   clk, resetn : shared with the parent; asynchronous active-low reset
//   pin_in      : raw asynchronous pin levels
//   edge_sel    : per pin, 0 = rising edge event, 1 = falling edge event
//   din         : synchronised pin levels (second synchroniser stage)
//   evt         : one-cycle event pulse per pin for the selected edge
module gpio_sync_edge #(
    parameter int unsigned GPIO_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [GPIO_W-1:0] pin_in,
    input  logic [GPIO_W-1:0] edge_sel,
    output logic [GPIO_W-1:0] din,
    output logic [GPIO_W-1:0] evt
);

    logic [GPIO_W-1:0] s1_q;
    logic [GPIO_W-1:0] s2_q;
    logic [GPIO_W-1:0] prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= pin_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign din = s2_q;
    assign evt = (s2_q & ~prev_q & ~edge_sel) | (~s2_q & prev_q & edge_sel);

endmodule

// File: rtl/apb_gpio_regs.sv
// APB3 slave register block implementing a small GPIO expander: output data and
// direction registers, synchronised input sampling and per-pin edge interrupts
// with write-1-to-clear status.
//   clk, resetn          : clock, asynchronous active-low reset
//   paddr/psel/penable/pwrite/pwdata : APB request (zero wait states)
//   prdata/pready/pslverr: APB response; prdata is 0 outside read access phase
//   gpio_in              : asynchronous pin inputs
//   gpio_out/gpio_oe     : pin output values and output enables
//   irq                  : level interrupt, |(IS & IE)
module apb_gpio_regs
    import gpio_regs_pkg::*;
#(
    parameter int unsigned GPIO_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);

    logic [GPIO_W-1:0] dout_q, dout_d;
    logic [GPIO_W-1:0] dir_q, dir_d;
    logic [GPIO_W-1:0] ie_q, ie_d;
    logic [GPIO_W-1:0] edge_q, edge_d;
    logic [GPIO_W-1:0] is_q, is_d;

    logic [GPIO_W-1:0] din;
    logic [GPIO_W-1:0] evt;
    logic [GPIO_W-1:0] wdata;
    logic [GPIO_W-1:0] rd_gpio;

    logic access;
    logic addr_mapped;
    logic addr_ro;
    logic wr_en;

    gpio_sync_edge #(
        .GPIO_W (GPIO_W)
    ) u_sync_edge (
        .clk      (clk),
        .resetn   (resetn),
        .pin_in   (gpio_in),
        .edge_sel (edge_q),
        .din      (din),
        .evt      (evt)
    );

    assign access      = psel & penable;
    assign addr_mapped = (paddr <= ADDR_W'(REG_IS));
    assign addr_ro     = (paddr == ADDR_W'(REG_DIN));
    // Erroring writes (unmapped or read-only target) must not touch state.
    assign wr_en       = access & pwrite & addr_mapped & ~addr_ro;
    assign wdata       = pwdata[GPIO_W-1:0];

    always_comb begin
        dout_d = dout_q;
        dir_d  = dir_q;
        ie_d   = ie_q;
        edge_d = edge_q;
        is_d   = is_q;
        if (wr_en) begin
            case (paddr)
                ADDR_W'(REG_DOUT): dout_d = wdata;
                ADDR_W'(REG_DIR):  dir_d  = wdata;
                ADDR_W'(REG_IE):   ie_d   = wdata;
                ADDR_W'(REG_EDGE): edge_d = wdata;
                ADDR_W'(REG_IS):   is_d   = is_q & ~wdata;
                default: ;
            endcase
        end
        // Applied after the W1C so a same-cycle event wins over the clear.
        is_d = is_d | (evt & ie_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q <= '0;
            dir_q  <= '0;
            ie_q   <= '0;
            edge_q <= '0;
            is_q   <= '0;
        end else begin
            dout_q <= dout_d;
            dir_q  <= dir_d;
            ie_q   <= ie_d;
            edge_q <= edge_d;
            is_q   <= is_d;
        end
    end

    always_comb begin
        rd_gpio = '0;
        case (paddr)
            ADDR_W'(REG_DOUT): rd_gpio = dout_q;
            ADDR_W'(REG_DIR):  rd_gpio = dir_q;
            ADDR_W'(REG_DIN):  rd_gpio = din;
            ADDR_W'(REG_IE):   rd_gpio = ie_q;
            ADDR_W'(REG_EDGE): rd_gpio = edge_q;
            ADDR_W'(REG_IS):   rd_gpio = is_q;
            default: ;
        endcase
    end

    assign prdata   = (access & ~pwrite) ? DATA_W'(rd_gpio) : '0;
    assign pready   = 1'b1;
    assign pslverr  = access & (~addr_mapped | (pwrite & addr_ro));
    assign gpio_out = dout_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(is_q & ie_q);

endmodule
